dispenser_ctrl: RTL and testbench

Dispense actuator controller for the vending machine. It consumes the single-cycle product strobes issued by the credit/selection FSM and queues them in a 4-entry FIFO. It then drives one motor per product for a fixed on-time and confirms each vend with a drop sensor, reporting completion or a jam fault. It is the receiving end of the FSM's `P` output bus.

---
 rtl/dispenser_ctrl.sv | 151 +++++++++++++++
 tb/tb_dispenser_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dispenser_ctrl.sv
// Dispense actuator controller: queues product strobes in a 4-entry FIFO, runs one
// motor per vend for a fixed on-time and confirms each vend with a drop sensor.
module dispenser_ctrl #(
    parameter int unsigned MOTOR_ON = 16,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] p_req,
    input  logic       drop_sense,
    input  logic       fault_clr,
    output logic [1:0] motor,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic       fault,
    output logic       overflow,
    output logic [2:0] pending
);
    localparam int unsigned CMAX = (MOTOR_ON > TIMEOUT) ? MOTOR_ON : TIMEOUT;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, RUN, WAIT_DROP, DONE, FAULT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cur_id;
    logic          seen;

    logic          sync1, sync2, sync_prev, drop_edge;
    logic          fifo_mem [4];
    logic [1:0]    rd_ptr, wr_ptr;
    logic          pop, flush, acc0, acc1;
    logic [2:0]    fill0;
    logic          unused_req;

    assign unused_req = p_req[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= drop_sense;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign drop_edge = sync2 & ~sync_prev;

    // Occupancy is judged on the registered count; a same-cycle pop does not free a slot.
    always_comb begin
        pop   = (state == IDLE) && (pending != 3'd0);
        flush = (state == WAIT_DROP) && !drop_edge && (cnt == CW'(1));
        acc0  = (state != FAULT) && p_req[0] && (pending < 3'd4);
        fill0 = pending + {2'b00, acc0};
        acc1  = (state != FAULT) && p_req[1] && (fill0 < 3'd4);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) fifo_mem[i] <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                pending <= '0;
            end else begin
                if (acc0) fifo_mem[wr_ptr] <= 1'b0;
                if (acc1) fifo_mem[wr_ptr + 2'(acc0)] <= 1'b1;
                wr_ptr  <= wr_ptr + 2'(acc0) + 2'(acc1);
                if (pop) rd_ptr <= rd_ptr + 2'd1;
                pending <= pending + 3'(acc0) + 3'(acc1) - 3'(pop);
            end
            // A drop in the same cycle as a clear still leaves the flag set.
            if (fault_clr) overflow <= 1'b0;
            if ((state != FAULT) && ((p_req[0] && !acc0) || (p_req[1] && !acc1)))
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_id  <= 1'b0;
            seen    <= 1'b0;
            motor   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            fault   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    cur_id <= fifo_mem[rd_ptr];
                    cnt    <= CW'(MOTOR_ON);
                    motor  <= fifo_mem[rd_ptr] ? 2'b10 : 2'b01;
                    busy   <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    if (cnt == CW'(1)) begin
                        motor <= '0;
                        if (seen || drop_edge) begin
                            done    <= 1'b1;
                            done_id <= cur_id;
                            state   <= DONE;
                        end else begin
                            cnt   <= CW'(TIMEOUT);
                            state <= WAIT_DROP;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                        if (drop_edge) seen <= 1'b1;
                    end
                end
                WAIT_DROP: begin
                    if (drop_edge) begin
                        done    <= 1'b1;
                        done_id <= cur_id;
                        state   <= DONE;
                    end else if (cnt == CW'(1)) begin
                        fault <= 1'b1;
                        state <= FAULT;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    seen  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                FAULT: if (fault_clr) begin
                    fault <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dispenser_ctrl.sv
// Bench for dispenser_ctrl: directed scenarios plus random request batches checked
// cycle by cycle against a vend-schedule model built from the timing rules.
module tb_dispenser_ctrl;
    localparam int M = 16;
    localparam int T = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] p_req;
    logic       drop_sense;
    logic       fault_clr;
    logic [1:0] motor;
    logic       busy, done, done_id, fault, overflow;
    logic [2:0] pending;

    always #5 clk = ~clk;

    dispenser_ctrl #(.MOTOR_ON(M), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .p_req(p_req), .drop_sense(drop_sense),
        .fault_clr(fault_clr), .motor(motor), .busy(busy), .done(done),
        .done_id(done_id), .fault(fault), .overflow(overflow), .pending(pending)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic exp_did = 1'b0;

    int         n_items;
    int         item_off [16];
    logic [2:0] item_bits [16];
    int         vend_delay [16];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, expv, cyc);
        end
    endtask

    // Request i (in acceptance order) becomes vend i: it starts two cycles after its
    // strobe or two cycles after the previous done, and finishes at the later of
    // motor-off and drop-rise + 3 (two sync stages plus edge detect).
    task automatic run_batch(input string name);
        int   base, nv, ovf_c, dcount, occ, last_d, pend, c;
        int   rt [16];
        int   st [16];
        int   dt [16];
        int   rr [16];
        logic vid [16];
        logic [1:0] em;
        logic eb, ed;
        base = cyc; nv = 0; ovf_c = 1 << 30; last_d = -100; dcount = 0;
        for (int k = 0; k < n_items; k++) begin
            c = base + item_off[k];
            occ = 0;
            for (int v = 0; v < nv; v++) begin
                if (rt[v] < c) occ++;
                if (st[v] <= c) occ--;
            end
            for (int b = 0; b < 2; b++) begin
                if (item_bits[k][b]) begin
                    if (occ < 4 && nv < 16) begin
                        occ++;
                        rt[nv]  = c;
                        vid[nv] = (b == 1);
                        st[nv]  = (last_d + 2 > c + 2) ? last_d + 2 : c + 2;
                        rr[nv]  = st[nv] + vend_delay[nv];
                        dt[nv]  = (st[nv] + M > rr[nv] + 3) ? st[nv] + M : rr[nv] + 3;
                        last_d  = dt[nv];
                        nv++;
                    end else if (c + 1 < ovf_c) begin
                        ovf_c = c + 1;
                    end
                end
            end
        end
        for (c = base; c <= last_d + 3; c++) begin
            em = 2'b00; eb = 1'b0; ed = 1'b0; pend = 0;
            for (int v = 0; v < nv; v++) begin
                if (c >= st[v] && c < st[v] + M) em = vid[v] ? 2'b10 : 2'b01;
                if (c >= st[v] && c <= dt[v]) eb = 1'b1;
                if (c == dt[v]) begin ed = 1'b1; exp_did = vid[v]; end
                if (rt[v] < c) pend++;
                if (st[v] <= c) pend--;
            end
            chk({name, "_motor"}, 32'(motor), 32'(em));
            chk({name, "_busy"}, 32'(busy), 32'(eb));
            chk({name, "_done"}, 32'(done), 32'(ed));
            chk({name, "_done_id"}, 32'(done_id), 32'(exp_did));
            chk({name, "_pending"}, 32'(pending), pend);
            chk({name, "_overflow"}, 32'(overflow), 32'(c >= ovf_c));
            if (done) dcount++;
            p_req = 3'b000;
            for (int k = 0; k < n_items; k++)
                if (base + item_off[k] == c) p_req = item_bits[k];
            drop_sense = 1'b0;
            for (int v = 0; v < nv; v++)
                if (c >= rr[v] && c <= rr[v] + 1) drop_sense = 1'b1;
            tick();
        end
        chk({name, "_done_count"}, dcount, nv);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk({name, "_ovf_clr"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        int base, s, f, pend;
        logic [2:0] patt [6];
        patt[0] = 3'b001; patt[1] = 3'b010; patt[2] = 3'b011;
        patt[3] = 3'b111; patt[4] = 3'b101; patt[5] = 3'b110;

        reset = 1'b1; p_req = 3'b000; drop_sense = 1'b0; fault_clr = 1'b0;
        repeat (3) tick();
        chk("rst_motor", 32'(motor), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        #2 reset = 1'b0;
        repeat (3) tick();

        n_items = 1; item_off[0] = 0; item_bits[0] = 3'b001; vend_delay[0] = M + 5;
        run_batch("single");

        n_items = 2; item_off[0] = 0; item_bits[0] = 3'b001;
        item_off[1] = 3; item_bits[1] = 3'b010;
        vend_delay[0] = 4; vend_delay[1] = 6;
        run_batch("queued");

        n_items = 1; item_off[0] = 0; item_bits[0] = 3'b011;
        vend_delay[0] = 2; vend_delay[1] = 3;
        run_batch("simul011");

        n_items = 1; item_off[0] = 0; item_bits[0] = 3'b111;
        vend_delay[0] = 2; vend_delay[1] = 3;
        run_batch("simul111");

        n_items = 6;
        for (int k = 0; k < 6; k++) begin
            item_off[k] = k; item_bits[k] = 3'b001; vend_delay[k] = 3;
        end
        run_batch("ovf");

        // Jam: no drop, extra strobes during RUN are flushed, strobe during FAULT ignored.
        base = cyc; s = base + 2; f = s + M + T;
        for (int c = base; c <= f + 3; c++) begin
            pend = 0;
            if (c < f) begin
                if (c > base) pend++;
                if (c > s + 3) pend++;
                if (c > s + 5) pend++;
                if (c >= s) pend--;
            end
            chk("jam_motor", 32'(motor), (c >= s && c < s + M) ? 32'd2 : 32'd0);
            chk("jam_busy", 32'(busy), 32'(c >= s));
            chk("jam_fault", 32'(fault), 32'(c >= f));
            chk("jam_pending", 32'(pending), pend);
            p_req = (c == base) ? 3'b010 :
                    (c == s + 3 || c == s + 5 || c == f + 1) ? 3'b001 : 3'b000;
            tick();
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("jam_clr_fault", 32'(fault), 32'd0);
        chk("jam_clr_busy", 32'(busy), 32'd0);
        chk("jam_clr_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("jam_after_motor", 32'(motor), 32'd0);
            chk("jam_after_pending", 32'(pending), 32'd0);
        end

        // Reset asserted mid-cycle during motor cycle 8 with one request still queued.
        base = cyc; s = base + 2;
        for (int c = base; c < s + 7; c++) begin
            p_req = (c == base) ? 3'b001 : (c == base + 1) ? 3'b010 : 3'b000;
            tick();
        end
        chk("rstrun_pre_motor", 32'(motor), 32'd1);
        chk("rstrun_pre_pending", 32'(pending), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstrun_motor", 32'(motor), 32'd0);
        chk("rstrun_busy", 32'(busy), 32'd0);
        chk("rstrun_done", 32'(done), 32'd0);
        chk("rstrun_done_id", 32'(done_id), 32'd0);
        chk("rstrun_fault", 32'(fault), 32'd0);
        chk("rstrun_overflow", 32'(overflow), 32'd0);
        chk("rstrun_pending", 32'(pending), 32'd0);
        exp_did = 1'b0;
        #2 reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("rstrun_idle_motor", 32'(motor), 32'd0);
            chk("rstrun_idle_busy", 32'(busy), 32'd0);
        end

        for (int b = 0; b < 12; b++) begin
            int off;
            off = 0;
            n_items = int'($urandom_range(1, 5));
            for (int k = 0; k < n_items; k++) begin
                item_off[k]  = off;
                item_bits[k] = patt[$urandom_range(0, 5)];
                off += int'($urandom_range(1, 3));
            end
            for (int v = 0; v < 16; v++)
                vend_delay[v] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, M - 3))
                                                             : int'($urandom_range(M - 2, M + 20));
            run_batch("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
